// File: rtl/uart_fifo_flagged.sv
// Single-clock FIFO between the UART datapaths and the host interface.
// Provides a registered read port, occupancy count, level flags, flush and sticky error flags.
module uart_fifo_flagged #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_LEVEL  = 12,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;
    logic                  push, pop;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    // A read on the same edge frees a slot, so a full FIFO still accepts wr&rd.
    assign push = wr & (~full | rd);
    assign pop  = rd & ~empty;

    // Storage carries no reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (Reset && !flush && push)
            mem[w_ptr] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            count     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (flush) begin
                w_ptr   <= '0;
                r_ptr   <= '0;
                count   <= '0;
                r_valid <= 1'b0;
            end else begin
                if (push)
                    w_ptr <= w_ptr + 1'b1;
                if (pop) begin
                    r_data <= mem[r_ptr];
                    r_ptr  <= r_ptr + 1'b1;
                end
                r_valid <= pop;
                count   <= count + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};
                // Error sets come after the clear so a same-edge event wins.
                if (wr & full & ~rd)
                    overflow <= 1'b1;
                if (rd & empty)
                    underflow <= 1'b1;
            end
        end
    end
endmodule
